// File: rtl/music_pkg.sv
// Shared types and constants for the music device note sequencer.
//   NOTE_W_DFLT / OCT_W_DFLT : default note-code and octave widths
//   REST_CODE                : all-ones note code, treated as a rest when enabled
//   seq_state_t              : playback FSM states
//   note_entry_t             : one stored slot {note, octave} at default widths
package music_pkg;

    localparam int unsigned NOTE_W_DFLT = 4;
    localparam int unsigned OCT_W_DFLT  = 2;

    localparam logic [NOTE_W_DFLT-1:0] REST_CODE = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [NOTE_W_DFLT-1:0] note;
        logic [OCT_W_DFLT-1:0]  octave;
    } note_entry_t;

endpackage

// File: rtl/note_store.sv
// Note slot buffer: DEPTH x W, one write port, one registered read port.
// Slot contents are not reset; only the read register is.
//   clk, reset      : clock, asynchronous active-low reset
//   we/waddr/wdata  : write strobe, slot address, slot data
//   re/raddr        : read strobe and slot address (data appears next cycle)
//   rdata           : registered read data, holds when re is low
module note_store #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned W     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q, rdata_d;

    // Storage array, no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback engine: appends keyboard notes to a slot buffer and plays
// them back as timed steps (LOAD + PLAY + GAP = STEP_TICKS cycles) with a gate.
// Optional macro NOTE_SEQ_REST_EN: all-ones note code plays as a silent rest.
//   clk, reset                    : clock, asynchronous active-low reset
//   rec_valid/rec_note/rec_octave : append one note (IDLE only)
//   play_start/play_stop/clear    : playback and buffer control strobes
//   loop_en                       : wrap to slot 0 after the last note
//   note_out/octave_out/gate      : current step and its gate
//   playing/play_idx              : non-IDLE flag and slot being played
//   count/full                    : fill level
//   done/overflow                 : completion and dropped-record pulses
module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned NOTE_W     = NOTE_W_DFLT,
    parameter int unsigned OCT_W      = OCT_W_DFLT,
    parameter int unsigned STEP_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rec_valid,
    input  logic [NOTE_W-1:0]          rec_note,
    input  logic [OCT_W-1:0]           rec_octave,
    input  logic                       play_start,
    input  logic                       play_stop,
    input  logic                       clear,
    input  logic                       loop_en,
    output logic [NOTE_W-1:0]          note_out,
    output logic [OCT_W-1:0]           octave_out,
    output logic                       gate,
    output logic                       playing,
    output logic [$clog2(DEPTH)-1:0]   play_idx,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       done,
    output logic                       overflow
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = IDX_W + 1;
    localparam int unsigned TICK_W   = $clog2(STEP_TICKS);
    localparam int unsigned ENT_W    = NOTE_W + OCT_W;
    localparam int unsigned PLAY_LEN = STEP_TICKS - GAP_TICKS - 1;

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   play_idx_q, play_idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [OCT_W-1:0]   oct_q, oct_d;
    logic               gate_q, gate_d;
    logic               playing_q, playing_d;
    logic               full_q, full_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               store_we;
    logic               store_re;
    logic [ENT_W-1:0]   store_rdata;
    logic               step_end;
    logic               more_notes;
    logic               is_rest_c;

    note_store #(
        .DEPTH (DEPTH),
        .AW    (IDX_W),
        .W     (ENT_W)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (store_we),
        .waddr (count_q[IDX_W-1:0]),
        .wdata ({rec_note, rec_octave}),
        .re    (store_re),
        .raddr (play_idx_d),
        .rdata (store_rdata)
    );

    // Slot read during LOAD lands in the output registers on entry to PLAY
    always_comb begin
        note_d = note_q;
        oct_d  = oct_q;
        if (state_q == LOAD) begin
            note_d = store_rdata[ENT_W-1:OCT_W];
            oct_d  = store_rdata[OCT_W-1:0];
        end
    end

`ifdef NOTE_SEQ_REST_EN
    localparam logic [NOTE_W-1:0] REST_NOTE = '1;
    assign is_rest_c = (note_d == REST_NOTE);
`else
    assign is_rest_c = 1'b0;
`endif

    assign more_notes = (({1'b0, play_idx_q} + CNT_W'(1)) < count_q);

    // Next-state and output logic; commands resolved clear > stop > start > rec
    always_comb begin
        state_d    = state_q;
        play_idx_d = play_idx_q;
        count_d    = count_q;
        tick_d     = tick_q;
        done_d     = 1'b0;
        ovf_d      = 1'b0;
        store_we   = 1'b0;
        step_end   = 1'b0;

        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            play_idx_d = '0;
            tick_d     = '0;
        end else if (play_stop) begin
            state_d    = IDLE;
            play_idx_d = '0;
            tick_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play_start) begin
                        if (count_q != '0) begin
                            state_d    = LOAD;
                            play_idx_d = '0;
                        end
                    end else if (rec_valid) begin
                        if (full_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            store_we = 1'b1;
                            count_d  = count_q + CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    state_d = PLAY;
                    tick_d  = '0;
                end
                PLAY: begin
                    if (tick_q == TICK_W'(PLAY_LEN - 1)) begin
                        tick_d = '0;
                        if (GAP_TICKS == 0) begin
                            step_end = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
                        tick_d   = '0;
                        step_end = 1'b1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            // Last slot either wraps (loop) or finishes the run
            if (step_end) begin
                if (more_notes) begin
                    play_idx_d = play_idx_q + IDX_W'(1);
                    state_d    = LOAD;
                end else if (loop_en) begin
                    play_idx_d = '0;
                    state_d    = LOAD;
                end else begin
                    play_idx_d = '0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end
        end

        store_re  = (state_d == LOAD);
        gate_d    = (state_d == PLAY) && !is_rest_c;
        playing_d = (state_d != IDLE);
        full_d    = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            play_idx_q <= '0;
            count_q    <= '0;
            tick_q     <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            gate_q     <= 1'b0;
            playing_q  <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            play_idx_q <= play_idx_d;
            count_q    <= count_d;
            tick_q     <= tick_d;
            note_q     <= note_d;
            oct_q      <= oct_d;
            gate_q     <= gate_d;
            playing_q  <= playing_d;
            full_q     <= full_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign note_out   = note_q;
    assign octave_out = oct_q;
    assign gate       = gate_q;
    assign playing    = playing_q;
    assign play_idx   = play_idx_q;
    assign count      = count_q;
    assign full       = full_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer (DEPTH=16, STEP_TICKS=8, GAP_TICKS=2).
// Stimulus pushes expected gated steps / done / overflow events; a negedge
// monitor pops and compares them as the DUT produces them.
module tb_note_sequencer;
    import music_pkg::*;

`ifdef NOTE_SEQ_REST_EN
    localparam bit REST_ON = 1'b1;
`else
    localparam bit REST_ON = 1'b0;
`endif

    localparam int EV_STEP = 0;
    localparam int EV_DONE = 1;
    localparam int EV_OVF  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rec_valid, play_start, play_stop, clear, loop_en;
    logic [3:0] rec_note;
    logic [1:0] rec_octave;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic       gate, playing, full, done, overflow;
    logic [3:0] play_idx;
    logic [4:0] count;

    note_sequencer #(
        .DEPTH      (16),
        .NOTE_W     (4),
        .OCT_W      (2),
        .STEP_TICKS (8),
        .GAP_TICKS  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_valid  (rec_valid),
        .rec_note   (rec_note),
        .rec_octave (rec_octave),
        .play_start (play_start),
        .play_stop  (play_stop),
        .clear      (clear),
        .loop_en    (loop_en),
        .note_out   (note_out),
        .octave_out (octave_out),
        .gate       (gate),
        .playing    (playing),
        .play_idx   (play_idx),
        .count      (count),
        .full       (full),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int note;
        int oct;
        int idx;
        int len;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecnt    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int n, input int o, input int i, input int l);
        exp_t e;
        e.kind = kind; e.note = n; e.oct = o; e.idx = i; e.len = l;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int n, input int o, input int i, input int l);
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected event kind", kind, -1);
        end else begin
            e = q.pop_front();
            chk("event kind", kind, e.kind);
            if (kind == EV_STEP && e.kind == EV_STEP) begin
                chk("step note", n, e.note);
                chk("step octave", o, e.oct);
                chk("step play_idx", i, e.idx);
                chk("step gate length", l, e.len);
            end
        end
    endtask

    // Monitor: one step event per gate pulse, plus done/overflow pulses
    logic gate_p = 1'b0;
    int   cap_note, cap_oct, cap_idx, cap_len;
    always @(negedge clk) begin
        if (reset) begin
            if (gate && !gate_p) begin
                cap_note = int'(note_out);
                cap_oct  = int'(octave_out);
                cap_idx  = int'(play_idx);
                cap_len  = 1;
            end else if (gate) begin
                cap_len++;
            end
            if (!gate && gate_p) pop_check(EV_STEP, cap_note, cap_oct, cap_idx, cap_len);
            if (done) pop_check(EV_DONE, 0, 0, 0, 0);
            if (overflow) pop_check(EV_OVF, 0, 0, 0, 0);
            gate_p = gate;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) tick();
    endtask

    task automatic rec(input int n, input int o);
        rec_valid  = 1'b1;
        rec_note   = 4'(n);
        rec_octave = 2'(o);
        tick();
        rec_valid  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic start();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        ecnt = 0;
    endtask

    task automatic wait_done(input string name, input int exp_edge);
        int found;
        found = -1;
        while (ecnt < exp_edge + 10) begin
            tick();
            if (done) begin
                found = ecnt;
                break;
            end
        end
        chk(name, found, exp_edge);
    endtask

    task automatic chk_reset_vals();
        chk("rst note_out", int'(note_out), 0);
        chk("rst octave_out", int'(octave_out), 0);
        chk("rst gate", int'(gate), 0);
        chk("rst playing", int'(playing), 0);
        chk("rst play_idx", int'(play_idx), 0);
        chk("rst count", int'(count), 0);
        chk("rst full", int'(full), 0);
        chk("rst done", int'(done), 0);
        chk("rst overflow", int'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hi;
        reset = 1'b0; rec_valid = 1'b0; play_start = 1'b0; play_stop = 1'b0;
        clear = 1'b0; loop_en = 1'b0; rec_note = '0; rec_octave = '0;
        #23;
        chk_reset_vals();
        reset = 1'b1;
        tick();

        // Basic record and play
        rec(3, 1); rec(5, 2); rec(7, 0);
        chk("count after 3 recs", int'(count), 3);
        push(EV_STEP, 3, 1, 0, 5);
        push(EV_STEP, 5, 2, 1, 5);
        push(EV_STEP, 7, 0, 2, 5);
        push(EV_DONE, 0, 0, 0, 0);
        start();
        chk("load playing", int'(playing), 1);
        chk("load gate", int'(gate), 0);
        tick();
        chk("first gate", int'(gate), 1);
        chk("first note", int'(note_out), 3);
        wait_done("basic done edge", 24);
        chk("basic playing after done", int'(playing), 0);
        tick();
        chk("done single pulse", int'(done), 0);

        // Overflow
        do_clear();
        chk("clear count", int'(count), 0);
        for (int i = 0; i < 16; i++) rec((i + 1) % 16, i % 4);
        chk("ovf count 16", int'(count), 16);
        chk("ovf full", int'(full), 1);
        push(EV_OVF, 0, 0, 0, 0);
        rec(5, 1);
        chk("overflow pulse", int'(overflow), 1);
        chk("count held at 16", int'(count), 16);
        tick();
        chk("overflow single pulse", int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            n = (i + 1) % 16;
            if (!(REST_ON && n == int'(REST_CODE))) push(EV_STEP, n, i % 4, i, 5);
        end
        push(EV_DONE, 0, 0, 0, 0);
        start();
        wait_done("full playback done edge", 128);

        // Loop, then end by dropping loop_en during the last step
        do_clear();
        rec(2, 0); rec(4, 3);
        loop_en = 1'b1;
        push(EV_STEP, 2, 0, 0, 5);
        push(EV_STEP, 4, 3, 1, 5);
        push(EV_STEP, 2, 0, 0, 5);
        push(EV_STEP, 4, 3, 1, 5);
        push(EV_DONE, 0, 0, 0, 0);
        start();
        run_to(9);
        chk("loop idx step1", int'(play_idx), 1);
        run_to(17);
        chk("loop idx after wrap", int'(play_idx), 0);
        chk("loop note after wrap", int'(note_out), 2);
        run_to(26);
        loop_en = 1'b0;
        wait_done("loop end done edge", 32);

        // Stop mid-PLAY, replay, clear
        do_clear();
        rec(6, 1); rec(9, 2);
        push(EV_STEP, 6, 1, 0, 3);
        start();
        run_to(3);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        chk("stop gate", int'(gate), 0);
        chk("stop playing", int'(playing), 0);
        chk("stop play_idx", int'(play_idx), 0);
        chk("stop keeps count", int'(count), 2);
        push(EV_STEP, 6, 1, 0, 5);
        push(EV_STEP, 9, 2, 1, 5);
        push(EV_DONE, 0, 0, 0, 0);
        start();
        wait_done("replay done edge", 16);
        do_clear();
        start();
        chk("start on empty playing", int'(playing), 0);
        chk("start on empty count", int'(count), 0);
        tick();
        chk("empty stays idle", int'(playing), 0);

        // Async reset mid-GAP
        rec(3, 2); rec(8, 1);
        push(EV_STEP, 3, 2, 0, 5);
        start();
        run_to(6);
        chk("in gap gate", int'(gate), 0);
        chk("in gap playing", int'(playing), 1);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        #1;
        reset = 1'b1;
        tick();

        // Rest note and start-vs-record priority
        rec(15, 1); rec(2, 0);
        if (!REST_ON) push(EV_STEP, 15, 1, 0, 5);
        push(EV_STEP, 2, 0, 1, 5);
        push(EV_DONE, 0, 0, 0, 0);
        play_start = 1'b1; rec_valid = 1'b1; rec_note = 4'd7; rec_octave = 2'd3;
        tick();
        play_start = 1'b0; rec_valid = 1'b0;
        ecnt = 0;
        chk("start beats rec count", int'(count), 2);
        chk("start beats rec playing", int'(playing), 1);
        hi = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (gate) hi++;
        end
        chk("note F gate cycles", hi, REST_ON ? 0 : 5);
        chk("note F step playing", int'(playing), 1);
        tick();
        chk("step after F gate", int'(gate), 1);
        chk("step after F note", int'(note_out), 2);
        wait_done("rest run done edge", 16);

        tick();
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised record/playback engine for the music device, the next generation of the fixed 16-note control/datapath pair. It stores keyboard notes (note + octave) in an internal buffer. It plays them back as a timed stream with a per-step gate, with optional looping and an articulation gap. It sits between the keyboard-input converter and the frequency/VGA datapath.

## Interface
- DEPTH, 16, number of note slots (power of two, ≥2)
- NOTE_W, 4, note code width
- OCT_W, 2, octave width
- STEP_TICKS, 12_500_000, clock cycles per played step (0.25 s at 50 MHz); must be ≥ GAP_TICKS+2
- GAP_TICKS, 1_250_000, gate-low cycles at end of each step (0 allowed)
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-low reset
- rec_valid  in  1  one-cycle strobe: append rec_note/rec_octave
- rec_note  in  NOTE_W  note code to record
- rec_octave  in  OCT_W  octave to record
- play_start  in  1  one-cycle strobe: begin playback at slot 0
- play_stop  in  1  one-cycle strobe: abort playback
- clear  in  1  one-cycle strobe: stop and empty buffer
- loop_en  in  1  level: wrap to slot 0 after last note
- note_out  out  NOTE_W  note of current step
- octave_out  out  OCT_W  octave of current step
- gate  out  1  high while current note sounds
- playing  out  1  high in any non-IDLE state
- play_idx  out  $clog2(DEPTH)  slot being played
- count  out  $clog2(DEPTH)+1  stored notes
- full  out  1  count == DEPTH
- done  out  1  one-cycle pulse on non-loop completion
- overflow  out  1  one-cycle pulse when rec_valid is dropped because full

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- Command priority per cycle: clear > play_stop > play_start > rec_valid.
- IDLE:
  - rec_valid with !full writes slot[count]; count increments.
  - rec_valid with full: no write; overflow pulses.
  - play_start with count>0 goes to LOAD with play_idx=0. play_start with count==0 is ignored.
- Any non-IDLE state: rec_valid is ignored without an overflow pulse; play_start is ignored.
- LOAD (1 cycle): synchronous buffer read of slot[play_idx]; gate=0. Next state PLAY.
- PLAY: note_out/octave_out hold the slot; gate=1 for STEP_TICKS−GAP_TICKS−1 cycles. Next state is GAP, or the step end if GAP_TICKS=0.
- GAP: gate=0 for GAP_TICKS cycles; note_out holds.
- Step end:
  - If play_idx<count−1: play_idx++ and go to LOAD.
  - Else, if loop_en (sampled that cycle) is high: play_idx=0 and go to LOAD.
  - Else: go to IDLE, done pulses, gate=0.
- play_stop when non-IDLE: go to IDLE next cycle with gate=0; buffer contents kept; play_idx returns to 0.
- clear: count=0, full=0, go to IDLE; slot contents need not be zeroed.
- Counters are unsigned and saturating-free; the tick counter is sized $clog2(STEP_TICKS).

## Timing
- Reset values: note_out=0, octave_out=0, gate=0, playing=0, play_idx=0, count=0, full=0, done=0, overflow=0; state=IDLE.
- Asynchronous reset mid-playback forces all of the above immediately.
- Recording: count/full update the cycle after rec_valid.
- Start latency: play_start at cycle t → playing=1 at t+1 (LOAD) → gate=1 and note valid at t+2.
- Each step occupies exactly STEP_TICKS cycles.
- done is registered and coincides with the first IDLE cycle.
- The loop wrap inserts no extra cycles.

## Configuration
- NOTE_SEQ_REST_EN defined: note code all-ones (REST_CODE) is a rest. Its step is timed normally but gate stays 0 throughout.
- NOTE_SEQ_REST_EN undefined: all-ones is an ordinary note and gates normally.

## Structure
- music_pkg holds:
  - NOTE_W/OCT_W defaults
  - REST_CODE constant
  - the seq_state_t enum (IDLE, LOAD, PLAY, GAP)
  - the packed note_entry_t struct {note, octave}
- One sub-module: note_store. This is a DEPTH × (NOTE_W+OCT_W) single-write-port, registered-read-port buffer, with no reset on contents.

## Test plan
- Basic record and play (STEP_TICKS=8, GAP_TICKS=2): record (3,1),(5,2),(7,0), pulse play_start.
  - Required: gate high 5 cycles then low 3 cycles per step, with note_out 3,5,7 in order.
  - After the third step: done pulses once at start+24; playing=0.
- Overflow (DEPTH=16): 17 rec_valid strobes.
  - Required: count=16, full=1, overflow pulses on the 17th strobe only; slot 15 still holds the 16th entry.
- Loop: 2 notes with loop_en=1.
  - Required: play_idx sequence 0,1,0,1 with no gap cycles beyond GAP_TICKS; no done pulse.
  - Deasserting loop_en during the last step ends playback at that step's end.
- Stop and clear: play_stop in mid-PLAY.
  - Required: gate=0 and playing=0 the next cycle; replay reproduces the same notes.
  - clear, then play_start: remains IDLE with count=0.
- Async reset: reset low mid-GAP.
  - Required: all outputs at reset values without a clock edge.
- Rest and priority: with NOTE_SEQ_REST_EN, record note F; step lasts 8 cycles with gate=0.
  - Simultaneous play_start and rec_valid in IDLE: playback starts and the note is not recorded.
